// File: rtl/div_pkg.sv
// Shared state encoding and width defaults for the sequential restoring divider.
package div_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int N_DEF = 8;
  localparam int D_DEF = 4;

  // Quotient reported on divide-by-zero; sliced down to N bits at the use site.
  localparam logic [63:0] DZ_QUOT = '1;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract,
// keep the difference only when it is non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int D = D_DEF
) (
  input  logic [D:0]   acc,
  input  logic         qmsb,
  input  logic [D-1:0] dvs,
  output logic [D:0]   acc_nxt,
  output logic         qbit
);
  // One spare bit above the shifted accumulator, so the sign of the trial
  // difference is exact.
  logic [D+1:0] sh;
  logic [D+1:0] trial;

  always_comb begin
    sh      = {acc, qmsb};
    trial   = sh - {2'b00, dvs};
    qbit    = ~trial[D+1];
    acc_nxt = qbit ? trial[D:0] : sh[D:0];
  end
endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, with built-in controller.
// Define DIV_SIGNED_EN for two's-complement operands (adds a FIX sign-correction state).
module seq_divider
  import div_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int D = D_DEF
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [N-1:0] dn,
  input  logic [D-1:0] dd,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic [D-1:0] r,
  output logic         dz
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state;
  logic [D:0]    acc;
  logic [N-1:0]  qreg;
  logic [D-1:0]  dreg;
  logic [CW-1:0] cnt;

  logic [D:0]    acc_nxt;
  logic          qbit;
  logic [N-1:0]  qreg_nxt;
  logic [N-1:0]  ld_q;
  logic [D-1:0]  ld_d;

`ifdef DIV_SIGNED_EN
  logic sq;
  logic sr;
  // The datapath is unsigned; signs are stripped here and restored in FIX.
  assign ld_q = dn[N-1] ? -dn : dn;
  assign ld_d = dd[D-1] ? -dd : dd;
`else
  assign ld_q = dn;
  assign ld_d = dd;
`endif

  div_step #(.D(D)) u_step (
    .acc     (acc),
    .qmsb    (qreg[N-1]),
    .dvs     (dreg),
    .acc_nxt (acc_nxt),
    .qbit    (qbit)
  );

  assign qreg_nxt = {qreg[N-2:0], qbit};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
      acc   <= '0;
      qreg  <= '0;
      dreg  <= '0;
      cnt   <= '0;
`ifdef DIV_SIGNED_EN
      sq    <= 1'b0;
      sr    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (dd == '0) begin
              state <= DONE;
              done  <= 1'b1;
              q     <= DZ_QUOT[N-1:0];
              r     <= '0;
              dz    <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              dz    <= 1'b0;
              acc   <= '0;
              qreg  <= ld_q;
              dreg  <= ld_d;
              cnt   <= CNT_INIT;
`ifdef DIV_SIGNED_EN
              sq    <= dn[N-1] ^ dd[D-1];
              sr    <= dn[N-1];
`endif
            end
          end
        end
        RUN: begin
          acc  <= acc_nxt;
          qreg <= qreg_nxt;
          cnt  <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
`ifdef DIV_SIGNED_EN
            state <= FIX;
`else
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            q     <= qreg_nxt;
            r     <= acc_nxt[D-1:0];
`endif
          end
        end
`ifdef DIV_SIGNED_EN
        FIX: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          q     <= sq ? -qreg : qreg;
          r     <= sr ? -acc[D-1:0] : acc[D-1:0];
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus a randomized sweep
// against a plain-arithmetic reference model (honours DIV_SIGNED_EN).
module tb_seq_divider;
  localparam int N = 8;
  localparam int D = 4;
`ifdef DIV_SIGNED_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = N + 1;
`endif

  logic         clk = 1'b0;
  logic         clr;
  logic         start;
  logic [N-1:0] dn;
  logic [D-1:0] dd;
  logic         busy;
  logic         done;
  logic [N-1:0] q;
  logic [D-1:0] r;
  logic         dz;

  int passed = 0;
  int total  = 0;

  seq_divider #(.N(N), .D(D)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .dn    (dn),
    .dd    (dd),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: ordinary integer division (truncating toward zero when signed).
  function automatic void model(input logic [N-1:0] a, input logic [D-1:0] b,
                                output logic [N-1:0] eq, output logic [D-1:0] er,
                                output logic edz);
    int sa, sb;
    if (b == '0) begin
      eq = '1; er = '0; edz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
`else
      sa = int'(a);
      sb = int'(b);
`endif
      eq = N'(sa / sb);
      er = D'(sa % sb);
      edz = 1'b0;
    end
  endfunction

  // Issue one divide; returns the cycle done was seen (0 on timeout) and busy-cycle count.
  // poke > 0 raises start again during that cycle of the run.
  task automatic do_div(input logic [N-1:0] a, input logic [D-1:0] b, input int poke,
                        output int lat, output int bcnt);
    dn = a; dd = b; start = 1'b1;
    cyc();
    start = 1'b0; dn = N'($urandom); dd = D'($urandom);
    lat = 0; bcnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin lat = c; break; end
      if (busy) bcnt++;
      if (c == poke) begin
        start = 1'b1; dn = 8'd1; dd = 4'd1;
      end else begin
        start = 1'b0;
      end
      cyc();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; dn = '0; dd = '0;
    cyc(); cyc();
    total++; if ({busy, done, q, r, dz} !== '0) $display("FAIL reset_outputs: got %h expected 0", {busy, done, q, r, dz}); else passed++;
    clr = 1'b0;
    cyc();
    total++; if ({busy, done} !== 2'b00) $display("FAIL reset_idle: got %b expected 00", {busy, done}); else passed++;
  endtask

  task automatic test_basic();
    int lat, bcnt;
    do_div(8'd100, 4'd7, 0, lat, bcnt);
    total++; if (lat !== LAT) $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); else passed++;
    total++; if (bcnt !== LAT - 1) $display("FAIL basic_busy_cycles: got %0d expected %0d", bcnt, LAT - 1); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b expected 0", busy); else passed++;
    total++; if (q !== 8'd14) $display("FAIL basic_q: got %0d expected 14", q); else passed++;
    total++; if (r !== 4'd2) $display("FAIL basic_r: got %0d expected 2", r); else passed++;
    total++; if (dz !== 1'b0) $display("FAIL basic_dz: got %b expected 0", dz); else passed++;
    cyc();
    total++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b expected 0", done); else passed++;
    total++; if (q !== 8'd14) $display("FAIL basic_q_held: got %0d expected 14", q); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic [N-1:0] eq; logic [D-1:0] er; logic edz;
    do_div(8'd200, 4'd15, 0, lat, bcnt);
    model(8'd200, 4'd15, eq, er, edz);
    total++; if ({q, r} !== {eq, er}) $display("FAIL b2b_first: got q=%0d r=%0d expected q=%0d r=%0d", q, r, eq, er); else passed++;
    cyc();
    do_div(8'd255, 4'd1, 0, lat, bcnt);
    model(8'd255, 4'd1, eq, er, edz);
    total++; if (lat !== LAT) $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT); else passed++;
    total++; if ({q, r} !== {eq, er}) $display("FAIL b2b_second: got q=%0d r=%0d expected q=%0d r=%0d", q, r, eq, er); else passed++;
    cyc();
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    do_div(8'd42, 4'd0, 0, lat, bcnt);
    total++; if (lat !== 1) $display("FAIL dz_latency: got %0d expected 1", lat); else passed++;
    total++; if ({q, r, dz} !== {8'hFF, 4'h0, 1'b1}) $display("FAIL dz_result: got q=%h r=%h dz=%b expected q=ff r=0 dz=1", q, r, dz); else passed++;
    total++; if (bcnt !== 0) $display("FAIL dz_busy: got %0d expected 0", bcnt); else passed++;
    cyc();
    total++; if (dz !== 1'b1) $display("FAIL dz_held: got %b expected 1", dz); else passed++;
    do_div(8'd100, 4'd7, 0, lat, bcnt);
    total++; if ({q, r, dz} !== {8'd14, 4'd2, 1'b0}) $display("FAIL dz_cleared: got q=%0d r=%0d dz=%b expected q=14 r=2 dz=0", q, r, dz); else passed++;
    cyc();
  endtask

  task automatic test_clr_mid();
    int lat, bcnt;
    dn = 8'd100; dd = 4'd7; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    total++; if (busy !== 1'b1) $display("FAIL clr_pre_busy: got %b expected 1", busy); else passed++;
    clr = 1'b1;
    #1;
    total++; if ({busy, done, q, r, dz} !== '0) $display("FAIL clr_async: got %h expected 0", {busy, done, q, r, dz}); else passed++;
    #2;
    clr = 1'b0;
    cyc();
    do_div(8'd100, 4'd7, 0, lat, bcnt);
    total++; if (lat !== LAT) $display("FAIL clr_restart_latency: got %0d expected %0d", lat, LAT); else passed++;
    total++; if ({q, r} !== {8'd14, 4'd2}) $display("FAIL clr_restart_result: got q=%0d r=%0d expected q=14 r=2", q, r); else passed++;
    cyc();
  endtask

  task automatic test_busy_ignore();
    int lat, bcnt, extra;
    do_div(8'd100, 4'd7, 3, lat, bcnt);
    total++; if (lat !== LAT) $display("FAIL ignore_latency: got %0d expected %0d", lat, LAT); else passed++;
    total++; if ({q, r} !== {8'd14, 4'd2}) $display("FAIL ignore_result: got q=%0d r=%0d expected q=14 r=2", q, r); else passed++;
    // start raised while in DONE must not launch another divide
    dn = 8'd3; dd = 4'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    extra = 0;
    for (int c = 0; c < LAT + 3; c++) begin
      if (done || busy) extra++;
      cyc();
    end
    total++; if (extra !== 0) $display("FAIL ignore_done_start: got %0d active cycles expected 0", extra); else passed++;
    total++; if ({q, r} !== {8'd14, 4'd2}) $display("FAIL ignore_held: got q=%0d r=%0d expected q=14 r=2", q, r); else passed++;
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    int lat, bcnt;
    do_div(8'h9C, 4'd7, 0, lat, bcnt);
    total++; if (lat !== 10) $display("FAIL signed_latency: got %0d expected 10", lat); else passed++;
    total++; if ({q, r} !== {8'hF2, 4'hE}) $display("FAIL signed_neg_dn: got q=%h r=%h expected q=f2 r=e", q, r); else passed++;
    cyc();
    do_div(8'd100, 4'h9, 0, lat, bcnt);
    total++; if ({q, r} !== {8'hF2, 4'h2}) $display("FAIL signed_neg_dd: got q=%h r=%h expected q=f2 r=2", q, r); else passed++;
    cyc();
    do_div(8'h80, 4'hF, 0, lat, bcnt);
    total++; if ({q, r, dz} !== {8'h80, 4'h0, 1'b0}) $display("FAIL signed_wrap: got q=%h r=%h dz=%b expected q=80 r=0 dz=0", q, r, dz); else passed++;
    cyc();
  endtask
`endif

  task automatic test_random();
    int lat, bcnt;
    logic [N-1:0] a, eq; logic [D-1:0] b, er; logic edz;
    for (int i = 0; i < 300; i++) begin
      a = N'($urandom);
      b = D'($urandom);
      model(a, b, eq, er, edz);
      do_div(a, b, 0, lat, bcnt);
      total++; if (lat !== (edz ? 1 : LAT)) $display("FAIL rand_latency dn=%0d dd=%0d: got %0d expected %0d", a, b, lat, edz ? 1 : LAT); else passed++;
      total++; if ({q, r, dz} !== {eq, er, edz}) $display("FAIL rand_result dn=%0d dd=%0d: got q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%b", a, b, q, r, dz, eq, er, edz); else passed++;
`ifndef DIV_SIGNED_EN
      if (b != '0) begin
        total++; if ((int'(q) * int'(b) + int'(r) != int'(a)) || (r >= b)) $display("FAIL rand_invariant dn=%0d dd=%0d: got q=%0d r=%0d expected dn=q*dd+r with r<dd", a, b, q, r); else passed++;
      end
`endif
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_clr_mid();
    test_busy_ignore();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
